// File: rtl/pipe_ctrl_pkg.sv
//==============================================================================
// Module   : pipe_ctrl_pkg
// Brief    : Shared types, constants and helpers for the pipeline hazard control
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package pipe_ctrl_pkg;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    localparam int DEF_MULDIV_CYCLES = 32;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        BUSY = 1'b1
    } md_state_t;

    // A destination matches a source only when it is written and is not $zero.
    function automatic logic reg_hit(input logic [4:0] dst, input logic we,
                                     input logic [4:0] src);
        return we && (dst != 5'd0) && (dst == src);
    endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_busy_timer.sv
//==============================================================================
// Module   : muldiv_busy_timer
// Brief    : RUN/BUSY tracker for the multi-cycle mult/div unit
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module muldiv_busy_timer
    import pipe_ctrl_pkg::*;
#(
    parameter int MULDIV_CYCLES = DEF_MULDIV_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic md_start,
    output logic md_busy
);

    localparam int             CW     = $clog2(MULDIV_CYCLES);
    localparam logic [CW-1:0]  C_LOAD = CW'(MULDIV_CYCLES - 1);

    md_state_t       r_state;
    md_state_t       w_state_next;
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   w_count_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= RUN;
            r_count <= '0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
        end
    end

    // Count holds MULDIV_CYCLES-1..0 while BUSY, giving exactly MULDIV_CYCLES busy cycles.
    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        case (r_state)
            RUN: begin
                if (md_start) begin
                    w_state_next = BUSY;
                    w_count_next = C_LOAD;
                end
            end
            BUSY: begin
                if (r_count == '0) begin
                    w_state_next = RUN;
                end else begin
                    w_count_next = r_count - 1'b1;
                end
            end
            default: begin
                w_state_next = RUN;
                w_count_next = '0;
            end
        endcase
    end

    assign md_busy = (r_state == BUSY);

    a_no_start_in_busy : assert property (@(posedge clk) disable iff (!rst_n)
        !((r_state == BUSY) && md_start));

endmodule

`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
//==============================================================================
// Module   : pipe_hazard_ctrl
// Brief    : Stall/flush/forwarding control for the 5-stage pipeline
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MULDIV_CYCLES = DEF_MULDIV_CYCLES,
    parameter int CNT_W         = 32
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [4:0]       rsD,
    input  logic [4:0]       rtD,
    input  logic [4:0]       rsE,
    input  logic [4:0]       rtE,
    input  logic [4:0]       writeRegE,
    input  logic [4:0]       writeRegM,
    input  logic [4:0]       writeRegW,
    input  logic             regWriteE,
    input  logic             regWriteM,
    input  logic             regWriteW,
    input  logic             memToRegE,
    input  logic             memToRegM,
    input  logic             branchD,
    input  logic             branchTakenD,
    input  logic             jumpD,
    input  logic             mdStartE,
    input  logic             mdUseD,
    output logic             stallF,
    output logic             stallD,
    output logic             flushD,
    output logic             flushE,
    output logic             fwdAD,
    output logic             fwdBD,
    output logic [1:0]       fwdAE,
    output logic [1:0]       fwdBE,
    output logic             mdBusy,
    output logic [CNT_W-1:0] stallCnt,
    output logic [CNT_W-1:0] flushCnt
);

    logic w_lw_stall;
    logic w_br_stall;
    logic w_md_stall;
    logic w_stall;
    logic w_flush_d;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    muldiv_busy_timer #(
        .MULDIV_CYCLES (MULDIV_CYCLES)
    ) u_md_timer (
        .clk      (CLK),
        .rst_n    (RST_N),
        .md_start (mdStartE),
        .md_busy  (mdBusy)
    );

    // MEM result is newer than WB, so it takes priority.
    always_comb begin
        fwdAE = FWD_RF;
        fwdBE = FWD_RF;
        if (reg_hit(writeRegM, regWriteM, rsE))      fwdAE = FWD_M;
        else if (reg_hit(writeRegW, regWriteW, rsE)) fwdAE = FWD_W;
        if (reg_hit(writeRegM, regWriteM, rtE))      fwdBE = FWD_M;
        else if (reg_hit(writeRegW, regWriteW, rtE)) fwdBE = FWD_W;
    end

    assign fwdAD = reg_hit(writeRegM, regWriteM, rsD);
    assign fwdBD = reg_hit(writeRegM, regWriteM, rtD);

    assign w_lw_stall = memToRegE &&
        (reg_hit(writeRegE, regWriteE, rsD) || reg_hit(writeRegE, regWriteE, rtD));
    assign w_br_stall = branchD &&
        (reg_hit(writeRegE, regWriteE, rsD) || reg_hit(writeRegE, regWriteE, rtD) ||
         (memToRegM && (reg_hit(writeRegM, regWriteM, rsD) ||
                        reg_hit(writeRegM, regWriteM, rtD))));
    assign w_md_stall = mdUseD && (mdBusy || mdStartE);

    assign w_stall   = w_lw_stall || w_br_stall || w_md_stall;
    // A stalled redirect is suppressed; it is seen again once the stall releases.
    assign w_flush_d = (branchTakenD || jumpD) && !w_stall;

    assign stallF = w_stall;
    assign stallD = w_stall;
    assign flushE = w_stall;
    assign flushD = w_flush_d;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != '1))   r_stall_cnt <= r_stall_cnt + 1'b1;
            if (w_flush_d && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    assign stallCnt = r_stall_cnt;
    assign flushCnt = r_flush_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
//==============================================================================
// Module   : tb_pipe_hazard_ctrl
// Brief    : Self-checking bench for pipe_hazard_ctrl (MULDIV_CYCLES=4, CNT_W=4)
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_pipe_hazard_ctrl;

    localparam int C_MD   = 4;
    localparam int C_CW   = 4;
    localparam int C_SATV = (1 << C_CW) - 1;

    typedef struct {
        logic [4:0] rsD, rtD, rsE, rtE, wE, wM, wW;
        logic       rwE, rwM, rwW, m2rE, m2rM, brD, btD, jD, mdS, mdU;
    } in_t;

    typedef struct {
        in_t        i;
        logic       stall, flush_d, fad, fbd;
        logic [1:0] fae, fbe;
    } vec_t;

    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    logic [4:0] rsD, rtD, rsE, rtE, writeRegE, writeRegM, writeRegW;
    logic regWriteE, regWriteM, regWriteW, memToRegE, memToRegM;
    logic branchD, branchTakenD, jumpD, mdStartE, mdUseD;
    logic stallF, stallD, flushD, flushE, fwdAD, fwdBD, mdBusy;
    logic [1:0] fwdAE, fwdBE;
    logic [C_CW-1:0] stallCnt, flushCnt;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: busy cycles remaining and plain integer counters.
    int m_busy_left = 0;
    int m_stall_cnt = 0;
    int m_flush_cnt = 0;
    logic last_stall, last_busy;

    vec_t tbl[$];

    always #5 CLK = ~CLK;

    pipe_hazard_ctrl #(.MULDIV_CYCLES(C_MD), .CNT_W(C_CW)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .writeRegE(writeRegE), .writeRegM(writeRegM), .writeRegW(writeRegW),
        .regWriteE(regWriteE), .regWriteM(regWriteM), .regWriteW(regWriteW),
        .memToRegE(memToRegE), .memToRegM(memToRegM),
        .branchD(branchD), .branchTakenD(branchTakenD), .jumpD(jumpD),
        .mdStartE(mdStartE), .mdUseD(mdUseD),
        .stallF(stallF), .stallD(stallD), .flushD(flushD), .flushE(flushE),
        .fwdAD(fwdAD), .fwdBD(fwdBD), .fwdAE(fwdAE), .fwdBE(fwdBE),
        .mdBusy(mdBusy), .stallCnt(stallCnt), .flushCnt(flushCnt)
    );

    function automatic in_t zin();
        in_t z;
        z.rsD = 0; z.rtD = 0; z.rsE = 0; z.rtE = 0; z.wE = 0; z.wM = 0; z.wW = 0;
        z.rwE = 0; z.rwM = 0; z.rwW = 0; z.m2rE = 0; z.m2rM = 0;
        z.brD = 0; z.btD = 0; z.jD = 0; z.mdS = 0; z.mdU = 0;
        return z;
    endfunction

    // "Does a written, non-zero destination feed this source?"
    function automatic bit feeds(logic we, logic [4:0] dst, logic [4:0] src);
        return (we == 1'b1) && (dst != 0) && (dst == src);
    endfunction

    function automatic int ex_sel(in_t x, logic [4:0] src);
        if (feeds(x.rwM, x.wM, src)) return 2;
        if (feeds(x.rwW, x.wW, src)) return 1;
        return 0;
    endfunction

    function automatic bit id_reads(in_t x, logic we, logic [4:0] dst);
        return feeds(we, dst, x.rsD) || feeds(we, dst, x.rtD);
    endfunction

    function automatic bit m_stall(in_t x);
        bit lw, br, md;
        lw = x.m2rE && id_reads(x, x.rwE, x.wE);
        br = x.brD && (id_reads(x, x.rwE, x.wE) || (x.m2rM && id_reads(x, x.rwM, x.wM)));
        md = x.mdU && (m_busy_left > 0 || x.mdS);
        return lw || br || md;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply(input in_t x, input logic rstn);
        RST_N = rstn;
        rsD = x.rsD; rtD = x.rtD; rsE = x.rsE; rtE = x.rtE;
        writeRegE = x.wE; writeRegM = x.wM; writeRegW = x.wW;
        regWriteE = x.rwE; regWriteM = x.rwM; regWriteW = x.rwW;
        memToRegE = x.m2rE; memToRegM = x.m2rM;
        branchD = x.brD; branchTakenD = x.btD; jumpD = x.jD;
        mdStartE = x.mdS; mdUseD = x.mdU;
    endtask

    // One cycle: drive, compare mid-cycle against the model, then advance the model.
    task automatic step(input in_t x, input logic rstn);
        bit s, f;
        apply(x, rstn);
        #4;
        s = m_stall(x);
        f = (x.btD || x.jD) && !s;
        chk("stallD", stallD, s);
        chk("stallF", stallF, s);
        chk("flushE", flushE, s);
        chk("flushD", flushD, f);
        chk("fwdAD", fwdAD, feeds(x.rwM, x.wM, x.rsD));
        chk("fwdBD", fwdBD, feeds(x.rwM, x.wM, x.rtD));
        chk("fwdAE", fwdAE, ex_sel(x, x.rsE));
        chk("fwdBE", fwdBE, ex_sel(x, x.rtE));
        chk("mdBusy", mdBusy, m_busy_left > 0);
        chk("stallCnt", stallCnt, m_stall_cnt);
        chk("flushCnt", flushCnt, m_flush_cnt);
        last_stall = stallD;
        last_busy  = mdBusy;
        @(posedge CLK);
        if (!rstn) begin
            m_busy_left = 0; m_stall_cnt = 0; m_flush_cnt = 0;
        end else begin
            if (s && m_stall_cnt < C_SATV) m_stall_cnt++;
            if (f && m_flush_cnt < C_SATV) m_flush_cnt++;
            if (m_busy_left > 0)   m_busy_left--;
            else if (x.mdS)        m_busy_left = C_MD;
        end
        #1;
    endtask

    task automatic add(input in_t x, input logic s, input logic f, input logic fad,
                       input logic fbd, input logic [1:0] fae, input logic [1:0] fbe);
        vec_t v;
        v.i = x; v.stall = s; v.flush_d = f; v.fad = fad; v.fbd = fbd; v.fae = fae; v.fbe = fbe;
        tbl.push_back(v);
    endtask

    initial begin
        in_t x;
        logic [6:0] pat_stall, pat_busy;

        x = zin(); x.m2rE = 1; x.rwE = 1; x.wE = 8; x.rsD = 8;          add(x, 1, 0, 0, 0, 2'b00, 2'b00);
        x = zin(); x.rwM = 1; x.wM = 9; x.rwW = 1; x.wW = 9; x.rsE = 9; add(x, 0, 0, 0, 0, 2'b10, 2'b00);
        x.wM = 0;                                                       add(x, 0, 0, 0, 0, 2'b01, 2'b00);
        x = zin(); x.brD = 1; x.rtD = 4; x.rwE = 1; x.wE = 4; x.btD = 1; add(x, 1, 0, 0, 0, 2'b00, 2'b00);
        x.rwE = 0; x.wE = 0;                                            add(x, 0, 1, 0, 0, 2'b00, 2'b00);
        x = zin(); x.rwM = 1; x.wM = 0; x.rwW = 1; x.wW = 0;            add(x, 0, 0, 0, 0, 2'b00, 2'b00);
        x = zin(); x.rwM = 1; x.wM = 5; x.rsD = 5; x.rtD = 5;           add(x, 0, 0, 1, 1, 2'b00, 2'b00);
        x = zin(); x.brD = 1; x.m2rM = 1; x.rwM = 1; x.wM = 6; x.rsD = 6; add(x, 1, 0, 1, 0, 2'b00, 2'b00);
        x = zin(); x.m2rE = 1; x.rwE = 1; x.wE = 7; x.rtD = 7; x.jD = 1; add(x, 1, 0, 0, 0, 2'b00, 2'b00);
        x = zin(); x.rwW = 1; x.wW = 3; x.rtE = 3;                      add(x, 0, 0, 0, 0, 2'b00, 2'b01);
        x = zin(); x.rwM = 0; x.wM = 9; x.rsE = 9; x.rtE = 9;           add(x, 0, 0, 0, 0, 2'b00, 2'b00);
        x = zin(); x.jD = 1;                                            add(x, 0, 1, 0, 0, 2'b00, 2'b00);

        // Power-up reset before any comparison.
        apply(zin(), 1'b0);
        repeat (2) @(posedge CLK);
        #1;
        step(zin(), 1'b1);

        foreach (tbl[k]) begin
            apply(tbl[k].i, 1'b1);
            #2;
            chk($sformatf("tbl%0d.stallD", k), stallD, tbl[k].stall);
            chk($sformatf("tbl%0d.flushD", k), flushD, tbl[k].flush_d);
            chk($sformatf("tbl%0d.fwdAD", k), fwdAD, tbl[k].fad);
            chk($sformatf("tbl%0d.fwdBD", k), fwdBD, tbl[k].fbd);
            chk($sformatf("tbl%0d.fwdAE", k), fwdAE, tbl[k].fae);
            chk($sformatf("tbl%0d.fwdBE", k), fwdBE, tbl[k].fbe);
            step(tbl[k].i, 1'b1);
        end

        for (int n = 0; n < 400; n++) begin
            x.rsD = 5'($urandom_range(0, 3)); x.rtD = 5'($urandom_range(0, 3));
            x.rsE = 5'($urandom_range(0, 3)); x.rtE = 5'($urandom_range(0, 3));
            x.wE  = 5'($urandom_range(0, 3)); x.wM  = 5'($urandom_range(0, 3));
            x.wW  = 5'($urandom_range(0, 3));
            x.rwE = 1'($urandom); x.rwM = 1'($urandom); x.rwW = 1'($urandom);
            x.m2rE = 1'($urandom); x.m2rM = 1'($urandom); x.brD = 1'($urandom);
            x.btD = 1'($urandom_range(0, 3) == 0); x.jD = 1'($urandom_range(0, 5) == 0);
            x.mdU = 1'($urandom);
            x.mdS = (m_busy_left == 0) && ($urandom_range(0, 7) == 0);
            step(x, 1'b1);
        end

        // Mult/div: stall on issue + 4 busy cycles, proceed on the 6th.
        step(zin(), 1'b0);
        x = zin(); x.mdS = 1; x.mdU = 1;
        step(x, 1'b1);
        pat_stall[0] = last_stall; pat_busy[0] = last_busy;
        x.mdS = 0;
        for (int k = 1; k < 7; k++) begin
            step(x, 1'b1);
            pat_stall[k] = last_stall; pat_busy[k] = last_busy;
        end
        chk("md_stall_pattern", pat_stall, 7'b0011111);
        chk("md_busy_pattern", pat_busy, 7'b0011110);

        // Reset two cycles into BUSY.
        x = zin(); x.mdS = 1;
        step(x, 1'b1);
        x.mdS = 0; x.mdU = 1;
        step(x, 1'b1);
        step(x, 1'b1);
        step(x, 1'b0);
        step(x, 1'b1);
        chk("rst_mid_busy.mdBusy", last_busy, 1'b0);
        chk("rst_mid_busy.stallD", last_stall, 1'b0);
        chk("rst_mid_busy.stallCnt", stallCnt, 0);
        chk("rst_mid_busy.flushCnt", flushCnt, 0);

        // Stall counter saturation.
        step(zin(), 1'b0);
        x = zin(); x.m2rE = 1; x.rwE = 1; x.wE = 8; x.rsD = 8;
        for (int k = 0; k < 20; k++) step(x, 1'b1);
        step(zin(), 1'b1);
        chk("sat.stallCnt", stallCnt, 15);
        step(x, 1'b1);
        step(x, 1'b1);
        chk("sat.stallCnt_hold", stallCnt, 15);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
